ksa_mp_sequencer: RTL and testbench

Multi-precision add/subtract sequencer built around a single 16-bit Kogge-Stone word adder.
- Accepts NWORDS*16-bit operands over a valid/ready handshake.
- Streams the operands through the word adder one 16-bit word per cycle, least-significant word first, chaining the carry in a register.
- Returns the full-width result, carry-out and signed overflow over a second valid/ready handshake.
- Sits between the operand-issue logic and the result writeback. It is the only user of its word adder.

---
 rtl/ksa_mp_sequencer.sv | 123 ++++++++++++
 tb/tb_ksa_mp_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ksa_mp_sequencer.sv
// ksa_mp_sequencer: multi-precision add/subtract sequencer built on one 16-bit Kogge-Stone word adder.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_ready high only in IDLE
//   in_a, in_b, in_sub  : W-bit operands, 0 = A+B, 1 = A-B
//   out_valid/out_ready : result handshake
//   out_sum, out_cout, out_ovf : registered W-bit result, carry-out (1 = no borrow), signed overflow
//   busy                : high while an operation is in RUN or DONE
// ksa16: 16-bit Kogge-Stone adder with carry-in folded into the bit-0 generate.
module ksa16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  function automatic logic [15:0] kg(input logic [15:0] g, input logic [15:0] p, input int d);
    logic [15:0] gn;
    gn = g;
    for (int i = 0; i < 16; i++)
      if (i >= d) gn[i] = g[i] | (p[i] & g[i - d]);
    return gn;
  endfunction
  function automatic logic [15:0] kp(input logic [15:0] p, input int d);
    logic [15:0] pn;
    pn = p;
    for (int i = 0; i < 16; i++)
      if (i >= d) pn[i] = p[i] & p[i - d];
    return pn;
  endfunction
  logic [15:0] p0, p1, p2, p3, g0, g1, g2, g3, g4;
  always_comb begin
    p0 = a ^ b;
    g0 = a & b;
    g0[0] = g0[0] | (p0[0] & cin);
    g1 = kg(g0, p0, 1);
    p1 = kp(p0, 1);
    g2 = kg(g1, p1, 2);
    p2 = kp(p1, 2);
    g3 = kg(g2, p2, 4);
    p3 = kp(p2, 4);
    g4 = kg(g3, p3, 8);
    // g4[i] is the carry out of bit i, so the carry into bit i is g4[i-1]
    sum = p0 ^ {g4[14:0], cin};
    cout = g4[15];
  end
endmodule

module ksa_mp_sequencer #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*NWORDS-1:0] in_a,
  input  logic [16*NWORDS-1:0] in_b,
  input  logic                 in_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*NWORDS-1:0] out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 busy
);
  localparam int W  = 16 * NWORDS;
  localparam int KW = $clog2(NWORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state;
  logic [W-1:0]  opa, opb;
  logic          carry;
  logic [KW-1:0] k;
  logic [15:0]   ws;
  logic          wc;
  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;
  ksa16 u_add (
    .a   (opa[{k, 4'b0} +: 16]),
    .b   (opb[{k, 4'b0} +: 16]),
    .cin (carry),
    .sum (ws),
    .cout(wc)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      opa       <= '0;
      opb       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opa   <= in_a;
          // subtract is A + ~B + 1: invert B here and seed the carry with 1
          opb   <= in_sub ? ~in_b : in_b;
          carry <= in_sub;
          k     <= '0;
          state <= RUN;
        end
        RUN: begin
          out_sum[{k, 4'b0} +: 16] <= ws;
          carry <= wc;
          k     <= k + 1'b1;
          if (k == KW'(NWORDS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_cout  <= wc;
            out_ovf   <= (opa[W-1] == opb[W-1]) && (ws[15] != opa[W-1]);
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ksa_mp_sequencer.sv
// tb_ksa_mp_sequencer: directed self-checking bench for ksa_mp_sequencer with NWORDS=4.
module tb_ksa_mp_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;
  logic [15:0] wa_a = '0;
  logic [15:0] wa_b = '0;
  logic        wa_cin = 1'b0;
  logic [15:0] wa_sum;
  logic        wa_cout;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ksa_mp_sequencer #(.NWORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .out_ovf(out_ovf), .busy(busy)
  );

  ksa16 wa (.a(wa_a), .b(wa_b), .cin(wa_cin), .sum(wa_sum), .cout(wa_cout));

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic sub, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 64'h0 || out_cout !== 1'b0 || out_ovf !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset got valid=%b sum=%h cout=%b ovf=%b busy=%b ready=%b exp 0 0 0 0 0 1", out_valid, out_sum, out_cout, out_ovf, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_chain();
    int lat;
    do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL chain_latency got=%0d exp=4", lat); end
    checks++;
    if (out_sum !== 64'h0000_0000_0001_0000 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      failures++; $display("FAIL chain_sum got=%h c=%b v=%b exp=0000000000010000 c=0 v=0", out_sum, out_cout, out_ovf);
    end
    consume();
  endtask

  task automatic test_wrap();
    int lat;
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    checks++;
    if (out_sum !== 64'h0 || out_cout !== 1'b1 || out_ovf !== 1'b0 || lat !== 4) begin
      failures++; $display("FAIL wrap got=%h c=%b v=%b lat=%0d exp=0 c=1 v=0 lat=4", out_sum, out_cout, out_ovf, lat);
    end
    consume();
    wa_a = 16'hFFFF; wa_b = 16'h0; wa_cin = 1'b1;
    #1;
    checks++;
    if (wa_sum !== 16'h0000 || wa_cout !== 1'b1) begin
      failures++; $display("FAIL word_cin got=%h c=%b exp=0000 c=1", wa_sum, wa_cout);
    end
    wa_a = 16'h1234; wa_b = 16'h1111; wa_cin = 1'b0;
    #1;
    checks++;
    if (wa_sum !== 16'h2345 || wa_cout !== 1'b0) begin
      failures++; $display("FAIL word_add got=%h c=%b exp=2345 c=0", wa_sum, wa_cout);
    end
    wa_a = 16'h8001; wa_b = 16'h7FFF; wa_cin = 1'b1;
    #1;
    checks++;
    if (wa_sum !== 16'h0001 || wa_cout !== 1'b1) begin
      failures++; $display("FAIL word_mix got=%h c=%b exp=0001 c=1", wa_sum, wa_cout);
    end
  endtask

  task automatic test_sub();
    int lat;
    do_op(64'h5, 64'h7, 1'b1, lat);
    checks++;
    if (out_sum !== 64'hFFFF_FFFF_FFFF_FFFE || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      failures++; $display("FAIL sub_borrow got=%h c=%b v=%b exp=fffffffffffffffe c=0 v=0", out_sum, out_cout, out_ovf);
    end
    consume();
    do_op(64'h7, 64'h5, 1'b1, lat);
    checks++;
    if (out_sum !== 64'h2 || out_cout !== 1'b1 || out_ovf !== 1'b0) begin
      failures++; $display("FAIL sub_noborrow got=%h c=%b v=%b exp=2 c=1 v=0", out_sum, out_cout, out_ovf);
    end
    consume();
  endtask

  task automatic test_overflow();
    int lat;
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    checks++;
    if (out_sum !== 64'h8000_0000_0000_0000 || out_cout !== 1'b0 || out_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_add got=%h c=%b v=%b exp=8000000000000000 c=0 v=1", out_sum, out_cout, out_ovf);
    end
    consume();
    do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, lat);
    checks++;
    if (out_sum !== 64'h7FFF_FFFF_FFFF_FFFF || out_cout !== 1'b1 || out_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_sub got=%h c=%b v=%b exp=7fffffffffffffff c=1 v=1", out_sum, out_cout, out_ovf);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    do_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, lat);
    checks++;
    if (out_sum !== 64'h1234_5678_9ABC_DF00 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      failures++; $display("FAIL bp_sum got=%h c=%b v=%b exp=123456789abcdf00 c=0 v=0", out_sum, out_cout, out_ovf);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_a = 64'hFFFF_0000_FFFF_0000 + 64'(i); in_b = 64'h0F0F_0F0F_0F0F_0F0F; in_sub = i[0];
      in_valid = i[1];
      @(posedge clk); #1;
      if (out_sum !== 64'h1234_5678_9ABC_DF00 || out_cout !== 1'b0 || out_ovf !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL bp_hold got=%0d unstable cycles exp=0 (sum=%h valid=%b ready=%b)", bad, out_sum, out_valid, in_ready);
    end
    @(negedge clk);
    in_a = 64'hAAAA; in_b = 64'h5555; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_release got valid=%b ready=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
    end
    do_op(64'h8000, 64'h8000, 1'b0, lat);
    checks++;
    if (out_sum !== 64'h1_0000 || out_cout !== 1'b0 || lat !== 4) begin
      failures++; $display("FAIL bp_next got=%h c=%b lat=%0d exp=10000 c=0 lat=4", out_sum, out_cout, lat);
    end
    consume();
  endtask

  task automatic test_async_reset();
    int lat;
    @(negedge clk);
    in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'hFFFF_FFFF_FFFF_FFFF; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || out_sum === 64'h0) begin
      failures++; $display("FAIL pre_reset got busy=%b sum=%h exp busy=1 sum nonzero", busy, out_sum);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 64'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL async_reset got valid=%b sum=%h busy=%b exp 0 0 0", out_valid, out_sum, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
    do_op(64'h1234, 64'h1111, 1'b0, lat);
    checks++;
    if (out_sum !== 64'h2345 || out_cout !== 1'b0 || out_ovf !== 1'b0 || lat !== 4) begin
      failures++; $display("FAIL post_reset got=%h c=%b v=%b lat=%0d exp=2345 c=0 v=0 lat=4", out_sum, out_cout, out_ovf, lat);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_chain();
    test_wrap();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
